// File: rtl/stream_arbiter_pkt.sv
// Round-robin stream arbiter with packet locking and a 2-entry output skid buffer.
// Output beats carry the index of the input channel they came from.
module stream_arbiter_pkt #(
  parameter int DATA_WIDTH  = 32,
  parameter int INPUT_NUM   = 4,
  parameter bit PACKET_MODE = 1'b1,
  parameter int ID_WIDTH    = $clog2(INPUT_NUM)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] s_data [INPUT_NUM],
  input  logic [INPUT_NUM-1:0]  s_last,
  input  logic [INPUT_NUM-1:0]  s_valid,
  output logic [INPUT_NUM-1:0]  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  locked
);

  // Handshake: a beat moves on an interface in every cycle where valid && ready
  // are both high. m_* stay stable while m_valid=1 and m_ready=0. s_ready is
  // derived from the registered buffer count, never from m_ready.

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int EW = ID_WIDTH + 1 + DATA_WIDTH;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]  lock_idx_q, lock_idx_d;
  logic [EW-1:0]        buf_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;
  logic                 can_accept, push, pop, any_valid;
  logic [ID_WIDTH-1:0]  arb_idx, gnt, gnt_next, scan_idx;
  int                   idx;

  assign can_accept = (count_q < 2'd2);
  assign m_valid    = (count_q != 2'd0) && !ARESET;
  assign pop        = m_valid && m_ready;
  assign {m_id, m_last, m_data} = buf_q[rd_ptr_q];
  assign locked     = (state_q == ST_LOCKED);

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    arb_idx   = rr_ptr_q;
    any_valid = 1'b0;
    idx       = 0;
    scan_idx  = '0;
    for (int k = INPUT_NUM - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= INPUT_NUM) idx = idx - INPUT_NUM;
      scan_idx = ID_WIDTH'(idx);
      if (s_valid[scan_idx]) begin
        arb_idx   = scan_idx;
        any_valid = 1'b1;
      end
    end
  end

  assign gnt      = (state_q == ST_LOCKED) ? lock_idx_q : arb_idx;
  assign gnt_next = (gnt == ID_WIDTH'(INPUT_NUM - 1)) ? '0 : gnt + ID_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    s_ready    = '0;
    if (!ARESET && (state_q == ST_LOCKED || any_valid)) s_ready[gnt] = can_accept;
    push = s_valid[gnt] && s_ready[gnt];
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          if (PACKET_MODE && !s_last[gnt]) begin
            state_d    = ST_LOCKED;
            lock_idx_d = gnt;
          end else begin
            rr_ptr_d = gnt_next;
          end
        end
      end
      ST_LOCKED: begin
        if (push && s_last[gnt]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = gnt_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      if (push) begin
        buf_q[wr_ptr_q] <= {gnt, s_last[gnt], s_data[gnt]};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_arbiter_pkt.sv
// Bench for stream_arbiter_pkt: a 4-input packet-mode instance and a 3-input
// beat-mode instance, directed sources with queued beats, and per-output scoreboards.
module tb_stream_arbiter_pkt;

  localparam int DW = 32;

  typedef struct packed { logic [1:0] gap; logic last; logic [DW-1:0] data; } beat_t;
  typedef struct packed { logic [1:0] id; logic last; logic [DW-1:0] data; } obeat_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: 4 inputs, packet mode
  logic [DW-1:0] a_s_data [4];
  logic [3:0]    a_s_last  = '0;
  logic [3:0]    a_s_valid = '0;
  logic [3:0]    a_s_ready;
  logic [DW-1:0] a_m_data;
  logic          a_m_last;
  logic [1:0]    a_m_id;
  logic          a_m_valid;
  logic          a_m_ready = 1'b1;
  logic          a_locked;

  // instance B: 3 inputs, beat mode
  logic [DW-1:0] b_s_data [3];
  logic [2:0]    b_s_last  = '0;
  logic [2:0]    b_s_valid = '0;
  logic [2:0]    b_s_ready;
  logic [DW-1:0] b_m_data;
  logic          b_m_last;
  logic [1:0]    b_m_id;
  logic          b_m_valid;
  logic          b_m_ready = 1'b1;
  logic          b_locked;

  stream_arbiter_pkt #(.DATA_WIDTH(DW), .INPUT_NUM(4), .PACKET_MODE(1'b1)) dut_a (
    .ACLK(clk), .ARESET(rst),
    .s_data(a_s_data), .s_last(a_s_last), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_last(a_m_last), .m_id(a_m_id), .m_valid(a_m_valid),
    .m_ready(a_m_ready), .locked(a_locked)
  );

  stream_arbiter_pkt #(.DATA_WIDTH(DW), .INPUT_NUM(3), .PACKET_MODE(1'b0)) dut_b (
    .ACLK(clk), .ARESET(rst),
    .s_data(b_s_data), .s_last(b_s_last), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_last(b_m_last), .m_id(b_m_id), .m_valid(b_m_valid),
    .m_ready(b_m_ready), .locked(b_locked)
  );

  function automatic beat_t mk(input logic [1:0] gap, input logic last, input logic [DW-1:0] d);
    mk = '{gap: gap, last: last, data: d};
  endfunction

  function automatic obeat_t mko(input logic [1:0] id, input logic last, input logic [DW-1:0] d);
    mko = '{id: id, last: last, data: d};
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // source drivers: each input presents the head of its queue, honouring a
  // per-beat gap (cycles of valid low before the beat is offered)
  beat_t      a_q [4][$];
  logic [3:0] a_acc   = '0;
  logic [3:0] a_fresh = '1;
  int         a_gap [4] = '{0, 0, 0, 0};
  bit         a_flush = 1'b0;

  always @(negedge clk) a_acc = a_s_valid & a_s_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 && a_flush) begin
        a_q[0].delete();
        a_fresh[0] = 1'b1;
        a_gap[0]   = 0;
      end
      if (a_acc[i] && a_q[i].size() != 0) begin
        void'(a_q[i].pop_front());
        a_fresh[i] = 1'b1;
      end
      if (a_fresh[i] && a_q[i].size() != 0) begin
        a_gap[i]   = int'(a_q[i][0].gap);
        a_fresh[i] = 1'b0;
      end
      if (a_q[i].size() != 0 && a_gap[i] == 0) begin
        a_s_valid[i] = 1'b1;
        a_s_data[i]  = a_q[i][0].data;
        a_s_last[i]  = a_q[i][0].last;
      end else begin
        a_s_valid[i] = 1'b0;
        if (a_gap[i] > 0) a_gap[i]--;
      end
    end
  end

  beat_t      b_q [3][$];
  logic [2:0] b_acc   = '0;
  logic [2:0] b_fresh = '1;
  int         b_gap [3] = '{0, 0, 0};

  always @(negedge clk) b_acc = b_s_valid & b_s_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (b_acc[i] && b_q[i].size() != 0) begin
        void'(b_q[i].pop_front());
        b_fresh[i] = 1'b1;
      end
      if (b_fresh[i] && b_q[i].size() != 0) begin
        b_gap[i]   = int'(b_q[i][0].gap);
        b_fresh[i] = 1'b0;
      end
      if (b_q[i].size() != 0 && b_gap[i] == 0) begin
        b_s_valid[i] = 1'b1;
        b_s_data[i]  = b_q[i][0].data;
        b_s_last[i]  = b_q[i][0].last;
      end else begin
        b_s_valid[i] = 1'b0;
        if (b_gap[i] > 0) b_gap[i]--;
      end
    end
  end

  // output ready for A: fixed level, or the stall pattern 1,0,0,1 repeating
  bit         bp_en      = 1'b0;
  logic       a_mr_level = 1'b1;
  logic [1:0] bp_idx     = 2'd0;
  logic [3:0] bp_pat     = 4'b1001;

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      a_m_ready = bp_pat[bp_idx];
      bp_idx    = bp_idx + 2'd1;
    end else begin
      a_m_ready = a_mr_level;
    end
  end

  // scoreboards / monitors
  obeat_t a_exp_q [$];
  obeat_t b_exp_q [$];
  obeat_t a_prev, b_prev;
  bit     a_stall = 1'b0;
  bit     b_stall = 1'b0;
  int     a_occ   = 0;
  bit     b_lock_seen = 1'b0;

  always @(negedge clk) begin
    obeat_t got, exp;
    got = mko(a_m_id, a_m_last, a_m_data);
    if (rst) begin
      a_stall = 1'b0;
      a_occ   = 0;
    end else begin
      if (a_stall) begin
        checks++;
        if (!a_m_valid || got != a_prev) begin
          errors++;
          $display("FAIL hold_a actual=%0h/v%0b required=%0h", got, a_m_valid, a_prev);
        end
      end
      if (bp_en && a_s_valid[1]) begin
        checks++;
        if (a_s_ready[1] != (a_occ < 2)) begin
          errors++;
          $display("FAIL ready_vs_occ_a actual=%0b required=%0b occ=%0d", a_s_ready[1], a_occ < 2, a_occ);
        end
      end
      if (a_m_valid && a_m_ready) begin
        checks++;
        if (a_exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_a actual=%0h required=none", got);
        end else begin
          exp = a_exp_q.pop_front();
          if (got != exp) begin
            errors++;
            $display("FAIL beat_a actual=%0h required=%0h", got, exp);
          end
        end
      end
      a_occ   = a_occ + int'(|(a_s_valid & a_s_ready)) - int'(a_m_valid && a_m_ready);
      a_stall = a_m_valid && !a_m_ready;
      a_prev  = got;
    end
  end

  always @(negedge clk) begin
    obeat_t got, exp;
    got = mko(b_m_id, b_m_last, b_m_data);
    if (rst) begin
      b_stall = 1'b0;
    end else begin
      if (b_locked) b_lock_seen = 1'b1;
      if (b_stall) begin
        checks++;
        if (!b_m_valid || got != b_prev) begin
          errors++;
          $display("FAIL hold_b actual=%0h required=%0h", got, b_prev);
        end
      end
      if (b_m_valid && b_m_ready) begin
        checks++;
        if (b_exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_b actual=%0h required=none", got);
        end else begin
          exp = b_exp_q.pop_front();
          if (got != exp) begin
            errors++;
            $display("FAIL beat_b actual=%0h required=%0h", got, exp);
          end
        end
      end
      b_stall = b_m_valid && !b_m_ready;
      b_prev  = got;
    end
  end

  task automatic wait_drain(input int limit, input string name);
    int n;
    n = 0;
    while ((a_exp_q.size() != 0 || b_exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(a_exp_q.size() == 0 && b_exp_q.size() == 0, name,
          64'(a_exp_q.size() + b_exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // directed sequence
  initial begin
    int n;
    // reset with every input offering three single-beat packets
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        a_q[i].push_back(mk(2'd0, 1'b1, DW'((i << 8) | k)));
        a_exp_q.push_back(mko(2'(i), 1'b1, DW'((i << 8) | k)));
      end
    end
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check(a_s_ready == 4'b0 && !a_m_valid && !a_locked, "reset_outputs",
            {a_s_ready, 2'b0, a_m_valid, a_locked}, 64'd0);
    end
    rst = 1'b0;
    #1;
    check(a_s_ready == 4'b0001, "first_grant", 64'(a_s_ready), 64'h1);

    // fairness: 0,1,2,3 repeating at one beat per cycle
    wait_drain(13, "fairness_throughput");

    // packet lock: input 2 sends A0, bubble, A1, A2 while input 3 waits
    @(negedge clk);
    a_q[2].push_back(mk(2'd0, 1'b0, 32'h2A0));
    a_q[2].push_back(mk(2'd2, 1'b0, 32'h2A1));
    a_q[2].push_back(mk(2'd0, 1'b1, 32'h2A2));
    a_q[3].push_back(mk(2'd0, 1'b1, 32'h3B0));
    a_q[3].push_back(mk(2'd0, 1'b1, 32'h3B1));
    a_exp_q.push_back(mko(2'd2, 1'b0, 32'h2A0));
    a_exp_q.push_back(mko(2'd2, 1'b0, 32'h2A1));
    a_exp_q.push_back(mko(2'd2, 1'b1, 32'h2A2));
    a_exp_q.push_back(mko(2'd3, 1'b1, 32'h3B0));
    a_exp_q.push_back(mko(2'd3, 1'b1, 32'h3B1));
    n = 0;
    while (!a_locked && n < 10) begin
      @(negedge clk);
      n++;
    end
    check(a_locked == 1'b1, "lock_entered", 64'(a_locked), 64'h1);
    n = 0;
    while (a_locked && n < 30) begin
      check(a_s_ready[3] == 1'b0, "lock_blocks_other", 64'(a_s_ready), 64'h4);
      @(negedge clk);
      n++;
    end
    check(a_locked == 1'b0, "lock_released", 64'(a_locked), 64'h0);
    wait_drain(20, "lock_drain");

    // backpressure: 10-beat packet from input 1 under a stalling sink
    @(negedge clk);
    bp_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_q[1].push_back(mk(2'd0, k == 9, DW'(32'h1000 + k)));
      a_exp_q.push_back(mko(2'd1, k == 9, DW'(32'h1000 + k)));
    end
    wait_drain(60, "backpressure_drain");
    @(negedge clk);
    bp_en = 1'b0;

    // mid-packet reset: two beats of a 4-beat packet buffered, then reset
    a_mr_level = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) a_q[0].push_back(mk(2'd0, k == 3, DW'(32'h4D0 + k)));
    repeat (5) @(negedge clk);
    check(a_m_valid && a_s_ready == 4'b0 && a_locked, "two_buffered",
          {a_s_ready, 2'b0, a_m_valid, a_locked}, 64'h3);
    rst     = 1'b1;
    a_flush = 1'b1;
    @(negedge clk);
    check(!a_m_valid && !a_locked && a_s_ready == 4'b0, "mid_reset_outputs",
          {a_s_ready, 2'b0, a_m_valid, a_locked}, 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    a_flush    = 1'b0;
    a_mr_level = 1'b1;
    #1;
    check(!a_m_valid, "buffer_dropped", 64'(a_m_valid), 64'd0);
    a_q[1].push_back(mk(2'd0, 1'b1, 32'h5C0));
    a_q[3].push_back(mk(2'd0, 1'b0, 32'h5D0));
    a_q[3].push_back(mk(2'd0, 1'b1, 32'h5D1));
    a_exp_q.push_back(mko(2'd1, 1'b1, 32'h5C0));
    a_exp_q.push_back(mko(2'd3, 1'b0, 32'h5D0));
    a_exp_q.push_back(mko(2'd3, 1'b1, 32'h5D1));
    wait_drain(20, "post_reset_packet");

    // wrap with 3 inputs, beat mode: move rr_ptr to 2, then 0 and 2 interleave
    @(negedge clk);
    b_q[1].push_back(mk(2'd0, 1'b1, 32'h6A0));
    b_exp_q.push_back(mko(2'd1, 1'b1, 32'h6A0));
    wait_drain(10, "wrap_setup");
    @(negedge clk);
    b_q[0].push_back(mk(2'd0, 1'b0, 32'h6E0));
    b_q[0].push_back(mk(2'd0, 1'b1, 32'h6E1));
    b_q[2].push_back(mk(2'd0, 1'b1, 32'h6F0));
    b_q[2].push_back(mk(2'd0, 1'b1, 32'h6F1));
    b_exp_q.push_back(mko(2'd2, 1'b1, 32'h6F0));
    b_exp_q.push_back(mko(2'd0, 1'b0, 32'h6E0));
    b_exp_q.push_back(mko(2'd2, 1'b1, 32'h6F1));
    b_exp_q.push_back(mko(2'd0, 1'b1, 32'h6E1));
    wait_drain(20, "wrap_interleave");
    check(b_lock_seen == 1'b0, "beat_mode_never_locks", 64'(b_lock_seen), 64'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
